// File: rtl/cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor
//
// Watches a CPU during one "run". The run lasts from start until halt or a
// cycle timeout. The block counts cycles and register write-backs and flags
// write-back values that match up to NUM_MATCH programmable targets. At the
// end of the run it gives a pass/fail verdict.
//
// Optional feature (macro CPU_RUN_MONITOR_LASTWB_EN): adds last_dest/last_data,
// which record the most recent write-back seen during RUN.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             begin a run (ignored while already running)
//   clear             abort/clear back to IDLE; beats start and halt
//   halt              CPU halt indication (sampled in RUN only)
//   reg_write         write-back strobe; wb_dest/wb_data qualify it
//   match_en          per-channel enable
//   match_val         per-channel target, channel i at [i*DATA_W +: DATA_W]
//   state             00 IDLE, 01 RUN, 10 HALTED, 11 TIMEOUT
//   busy              state == RUN
//   done              one-cycle pulse on the first cycle in HALTED/TIMEOUT
//   pass              verdict, 1 only in HALTED with every enabled channel hit
//   cycles, wb_count  saturating RUN cycle / write-back counters
//   matched           sticky per-channel hit flags
//   match_dest        wb_dest of each channel's first hit, REG_AW per channel
//   last_dest/data    (optional) most recent RUN write-back
// ---------------------------------------------------------------------------
module cpu_run_monitor #(
  parameter int DATA_W     = 24,
  parameter int REG_AW     = 6,
  parameter int NUM_MATCH  = 4,
  parameter int CYC_W      = 20,
  parameter int MAX_CYCLES = 353259
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        clear,
  input  logic                        halt,
  input  logic                        reg_write,
  input  logic [REG_AW-1:0]           wb_dest,
  input  logic [DATA_W-1:0]           wb_data,
  input  logic [NUM_MATCH-1:0]        match_en,
  input  logic [NUM_MATCH*DATA_W-1:0] match_val,
  output logic [1:0]                  state,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [CYC_W-1:0]            cycles,
  output logic [CYC_W-1:0]            wb_count,
  output logic [NUM_MATCH-1:0]        matched,
  output logic [NUM_MATCH*REG_AW-1:0] match_dest
`ifdef CPU_RUN_MONITOR_LASTWB_EN
  ,
  output logic [REG_AW-1:0]           last_dest,
  output logic [DATA_W-1:0]           last_data
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_HALTED  = 2'b10,
    S_TIMEOUT = 2'b11
  } state_e;

  localparam logic [CYC_W-1:0] CNT_MAX  = '1;
  // Last RUN cycle before timeout; passing it leaves cycles == MAX_CYCLES.
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYCLES - 1);

  state_e                        state_q, state_d;
  logic                          done_q, done_d;
  logic                          pass_q, pass_d;
  logic [CYC_W-1:0]              cycles_q, cycles_d;
  logic [CYC_W-1:0]              wb_count_q, wb_count_d;
  logic [NUM_MATCH-1:0]          matched_q, matched_d;
  logic [NUM_MATCH*REG_AW-1:0]   match_dest_q, match_dest_d;
`ifdef CPU_RUN_MONITOR_LASTWB_EN
  logic [REG_AW-1:0]             last_dest_q, last_dest_d;
  logic [DATA_W-1:0]             last_data_q, last_data_d;
`endif

  // Either clear or a start outside RUN wipes all run results.
  logic wipe;
  assign wipe = clear || (start && (state_q != S_RUN));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d      = state_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    cycles_d     = cycles_q;
    wb_count_d   = wb_count_q;
    matched_d    = matched_q;
    match_dest_d = match_dest_q;
`ifdef CPU_RUN_MONITOR_LASTWB_EN
    last_dest_d  = last_dest_q;
    last_data_d  = last_data_q;
`endif

    if (wipe) begin
      state_d      = clear ? S_IDLE : S_RUN;
      pass_d       = 1'b0;
      cycles_d     = '0;
      wb_count_d   = '0;
      matched_d    = '0;
      match_dest_d = '0;
`ifdef CPU_RUN_MONITOR_LASTWB_EN
      last_dest_d  = '0;
      last_data_d  = '0;
`endif
    end else if (state_q == S_RUN) begin
      if (cycles_q != CNT_MAX) cycles_d = cycles_q + CYC_W'(1);

      if (reg_write) begin
        if (wb_count_q != CNT_MAX) wb_count_d = wb_count_q + CYC_W'(1);
        for (int i = 0; i < NUM_MATCH; i++) begin
          // First hit only: the flag being clear is what freezes match_dest.
          if (match_en[i] && !matched_q[i] &&
              (wb_data == match_val[i*DATA_W +: DATA_W])) begin
            matched_d[i]                     = 1'b1;
            match_dest_d[i*REG_AW +: REG_AW] = wb_dest;
          end
        end
`ifdef CPU_RUN_MONITOR_LASTWB_EN
        last_dest_d = wb_dest;
        last_data_d = wb_data;
`endif
      end

      // halt wins over a coincident timeout.
      if (halt) begin
        state_d = S_HALTED;
        done_d  = 1'b1;
        // Use matched_d so a hit on the halting write-back still counts.
        pass_d  = &(matched_d | ~match_en);
      end else if (cycles_q == LAST_CYC) begin
        state_d = S_TIMEOUT;
        done_d  = 1'b1;
        pass_d  = 1'b0;
      end
    end
  end

  // NOTE: reset is asynchronous, so it sits in the sensitivity list and clears state without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      cycles_q     <= '0;
      wb_count_q   <= '0;
      matched_q    <= '0;
      match_dest_q <= '0;
`ifdef CPU_RUN_MONITOR_LASTWB_EN
      last_dest_q  <= '0;
      last_data_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments give every flop its pre-edge value, so the order of these lines does not matter.
      state_q      <= state_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      cycles_q     <= cycles_d;
      wb_count_q   <= wb_count_d;
      matched_q    <= matched_d;
      match_dest_q <= match_dest_d;
`ifdef CPU_RUN_MONITOR_LASTWB_EN
      last_dest_q  <= last_dest_d;
      last_data_q  <= last_data_d;
`endif
    end
  end

  assign state      = state_q;
  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign pass       = pass_q;
  assign cycles     = cycles_q;
  assign wb_count   = wb_count_q;
  assign matched    = matched_q;
  assign match_dest = match_dest_q;
`ifdef CPU_RUN_MONITOR_LASTWB_EN
  assign last_dest  = last_dest_q;
  assign last_data  = last_data_q;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_monitor
//
// Directed bench for cpu_run_monitor. It uses MAX_CYCLES=16 so that the
// timeout scenarios stay short. Inputs change 1 time unit after each rising
// edge. Outputs are checked at the same point, so they show the effect of
// the edge that has just passed.
// ---------------------------------------------------------------------------
module tb_cpu_run_monitor;

  localparam int DATA_W     = 24;
  localparam int REG_AW     = 6;
  localparam int NUM_MATCH  = 4;
  localparam int CYC_W      = 20;
  localparam int MAX_CYCLES = 16;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start, clear, halt, reg_write;
  logic [REG_AW-1:0]           wb_dest;
  logic [DATA_W-1:0]           wb_data;
  logic [NUM_MATCH-1:0]        match_en;
  logic [NUM_MATCH*DATA_W-1:0] match_val;
  logic [1:0]                  state;
  logic                        busy, done, pass;
  logic [CYC_W-1:0]            cycles, wb_count;
  logic [NUM_MATCH-1:0]        matched;
  logic [NUM_MATCH*REG_AW-1:0] match_dest;
`ifdef CPU_RUN_MONITOR_LASTWB_EN
  logic [REG_AW-1:0]           last_dest;
  logic [DATA_W-1:0]           last_data;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cpu_run_monitor #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_MATCH(NUM_MATCH),
    .CYC_W(CYC_W), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .halt(halt),
    .reg_write(reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
    .match_en(match_en), .match_val(match_val),
    .state(state), .busy(busy), .done(done), .pass(pass),
    .cycles(cycles), .wb_count(wb_count), .matched(matched),
    .match_dest(match_dest)
`ifdef CPU_RUN_MONITOR_LASTWB_EN
    , .last_dest(last_dest), .last_data(last_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".state"},      state,      2'b00);
    check({tag, ".busy"},       busy,       1'b0);
    check({tag, ".done"},       done,       1'b0);
    check({tag, ".pass"},       pass,       1'b0);
    check({tag, ".cycles"},     cycles,     '0);
    check({tag, ".wb_count"},   wb_count,   '0);
    check({tag, ".matched"},    matched,    '0);
    check({tag, ".match_dest"}, match_dest, '0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; clear = 1'b0; halt = 1'b0; reg_write = 1'b0;
    wb_dest = '0; wb_data = '0; match_en = '0; match_val = '0;

    // Reset is asynchronous: check the outputs before any clock edge.
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
`ifdef CPU_RUN_MONITOR_LASTWB_EN
    check("reset.last_dest", last_dest, '0);
    check("reset.last_data", last_data, '0);
`endif
    rst = 1'b0;
    step();
    check("idle_wait.state", state, 2'b00);

    // Halt on the 10th RUN cycle.
    start = 1'b1; step(); start = 1'b0;
    check("s1.state_run", state, 2'b01);
    check("s1.busy", busy, 1'b1);
    check("s1.cycles0", cycles, 0);
    repeat (9) step();
    check("s1.cycles9", cycles, 9);
    halt = 1'b1; step(); halt = 1'b0;
    check("s1.state", state, 2'b10);
    check("s1.cycles", cycles, 10);
    check("s1.done", done, 1'b1);
    check("s1.pass", pass, 1'b1);
    check("s1.busy_off", busy, 1'b0);
    // Outside RUN, halt and reg_write do nothing; done is a single pulse.
    halt = 1'b1; reg_write = 1'b1; step(); halt = 1'b0; reg_write = 1'b0;
    check("s1.done_gone", done, 1'b0);
    check("s1.hold_cycles", cycles, 10);
    check("s1.hold_wb", wb_count, 0);
    check("s1.hold_state", state, 2'b10);

    // First-hit capture on channel 0, restart from HALTED, start ignored in RUN.
    match_en  = 4'b0001;
    match_val = {24'd0, 24'd0, 24'd99, 24'd7};
    start = 1'b1; step(); start = 1'b0;
    check("s2.state", state, 2'b01);
    check("s2.cycles0", cycles, 0);
    check("s2.pass_run", pass, 1'b0);
    reg_write = 1'b1; wb_dest = 6'd3; wb_data = 24'd5; step();
    check("s2.no_hit", matched, 4'b0000);
    wb_dest = 6'd5; wb_data = 24'd7; start = 1'b1; step(); start = 1'b0;
    check("s2.hit", matched, 4'b0001);
    check("s2.start_ignored", cycles, 2);
    wb_dest = 6'd9; wb_data = 24'd7; halt = 1'b1; step();
    halt = 1'b0; reg_write = 1'b0;
    check("s2.state", state, 2'b10);
    check("s2.matched", matched, 4'b0001);
    check("s2.match_dest", match_dest, 24'h000005);
    check("s2.wb_count", wb_count, 3);
    check("s2.pass", pass, 1'b1);
    check("s2.done", done, 1'b1);

    // Enabled channel 1 never hits: verdict fails. The hit on the halting write-back still counts.
    match_en = 4'b0011;
    start = 1'b1; step(); start = 1'b0;
    check("s2b.matched_zeroed", matched, 4'b0000);
    reg_write = 1'b1; wb_dest = 6'd4; wb_data = 24'd7; halt = 1'b1; step();
    reg_write = 1'b0; halt = 1'b0;
    check("s2b.state", state, 2'b10);
    check("s2b.matched", matched, 4'b0001);
    check("s2b.match_dest", match_dest, 24'h000004);
    check("s2b.pass", pass, 1'b0);

    // Timeout after 16 RUN cycles.
    match_en = 4'b0000;
    start = 1'b1; step(); start = 1'b0;
    repeat (15) step();
    check("s3.state_pre", state, 2'b01);
    check("s3.cycles_pre", cycles, 15);
    step();
    check("s3.state", state, 2'b11);
    check("s3.cycles", cycles, 16);
    check("s3.done", done, 1'b1);
    check("s3.pass", pass, 1'b0);
    reg_write = 1'b1; halt = 1'b1; step(); reg_write = 1'b0; halt = 1'b0;
    check("s3.state_hold", state, 2'b11);
    check("s3.wb_hold", wb_count, 0);
    check("s3.done_gone", done, 1'b0);

    // Halt in the timeout cycle: HALTED wins.
    start = 1'b1; step(); start = 1'b0;
    repeat (15) step();
    halt = 1'b1; step(); halt = 1'b0;
    check("s4.state", state, 2'b10);
    check("s4.cycles", cycles, 16);
    check("s4.done", done, 1'b1);
    check("s4.pass", pass, 1'b1);

    // rst mid-RUN: immediate zeroing, no done pulse afterwards.
    match_en = 4'b0001;
    start = 1'b1; step(); start = 1'b0;
    reg_write = 1'b1; wb_dest = 6'd1; wb_data = 24'd7; step(); reg_write = 1'b0;
    step();
    check("s5a.matched_pre", matched, 4'b0001);
    #2 rst = 1'b1;
    #1 check_all_zero("s5a.rst");
    rst = 1'b0;
    step();
    check("s5a.idle", state, 2'b00);
    check("s5a.no_done", done, 1'b0);
    step();
    check("s5a.no_done2", done, 1'b0);

    // clear together with start and halt mid-RUN.
    start = 1'b1; step(); start = 1'b0;
    reg_write = 1'b1; wb_dest = 6'd8; wb_data = 24'd7; step(); reg_write = 1'b0;
    step();
    check("s5b.matched_pre", matched, 4'b0001);
    clear = 1'b1; start = 1'b1; halt = 1'b1; step();
    clear = 1'b0; start = 1'b0; halt = 1'b0;
    check_all_zero("s5b.clear");
    step();
    check("s5b.no_done", done, 1'b0);

    // Last write-back capture, or identical core behaviour without the feature.
    match_en = 4'b0000;
    start = 1'b1; step(); start = 1'b0;
    reg_write = 1'b1; wb_dest = 6'd2; wb_data = 24'h00ABCD; halt = 1'b1; step();
    reg_write = 1'b0; halt = 1'b0;
    check("s6.state", state, 2'b10);
    check("s6.cycles", cycles, 1);
    check("s6.pass", pass, 1'b1);
    check("s6.wb_count", wb_count, 1);
`ifdef CPU_RUN_MONITOR_LASTWB_EN
    check("s6.last_dest", last_dest, 6'd2);
    check("s6.last_data", last_data, 24'h00ABCD);
    clear = 1'b1; step(); clear = 1'b0;
    check("s6.last_dest_clr", last_dest, '0);
    check("s6.last_data_clr", last_data, '0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
